// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and IF/ID register.
// The IF/ID register is carried as one packed struct so it can be held and cleared as a unit.
package fetch_stage_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

   localparam int IFID_INST_W  = XLEN;
   localparam int IFID_PC4_W   = XLEN;
   localparam int IFID_VALID_W = 1;

   typedef struct packed {
      logic [IFID_VALID_W-1:0] valid;
      logic [IFID_PC4_W-1:0]   pc4;
      logic [IFID_INST_W-1:0]  inst;
   } ifIdT;

   localparam int IFID_W = $bits(ifIdT);
endpackage

// File: rtl/fetch_stage_pipe_reg.sv
// Width-parameterised pipeline register: async active-low reset, load enable, sync clear.
// Clear only takes effect when the register is enabled, so a held stage cannot be squashed.
module pipe_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= '0;
      else if (en)  q <= clr ? '0 : d;
   end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, optional stall counter.
// Define STALL_CNT_EN to build the saturating stall counter; otherwise StallCount reads 0.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PcWrite,
   input  logic             IF_ID_Write,
   input  logic             Flush,
   input  logic [31:0]      BranchTarget,
   input  logic [31:0]      InstIn,
   output logic [31:0]      PcOut,
   output logic [31:0]      IF_ID_Pc4,
   output logic [31:0]      IF_ID_Inst,
   output logic             IF_ID_Valid,
   output logic [CNT_W-1:0] StallCount
);
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pcPlus4;
   ifIdT            ifIdD;
   ifIdT            ifIdQ;

   assign pcPlus4 = pc + PC_STEP;

   // A stalled PC swallows any flush; the hazard unit re-presents the branch later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pc <= RESET_PC;
      else if (PcWrite) pc <= Flush ? BranchTarget : pcPlus4;
   end

   assign ifIdD.valid = 1'b1;
   assign ifIdD.pc4   = pcPlus4;
   assign ifIdD.inst  = InstIn;

   // Clearing yields inst = NOP_INST (all zero), pc4 = 0, valid = 0.
   pipe_reg #(.WIDTH(IFID_W)) uIfId (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (IF_ID_Write),
      .clr   (Flush & PcWrite),
      .d     (ifIdD),
      .q     (ifIdQ)
   );

   assign PcOut       = pc;
   assign IF_ID_Pc4   = ifIdQ.pc4;
   assign IF_ID_Inst  = ifIdQ.inst;
   assign IF_ID_Valid = ifIdQ.valid;

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] stallCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          stallCnt <= '0;
      else if (!PcWrite && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
   end

   assign StallCount = stallCnt;
`else
   assign StallCount = '0;
`endif
endmodule
